// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor. Computes a - b one bit per clock,
// LSB first, using one full-adder cell and a carry flop: a + ~b + 1.
// A controller pulses start with operands, waits for the done pulse and then
// reads the difference together with the borrow and signed-overflow flags.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   start      in   1      operation request, only looked at while idle
//   a          in   WIDTH  minuend, captured when start is accepted
//   b          in   WIDTH  subtrahend, captured when start is accepted
//   busy       out  1      high from the accepting edge until DONE is left
//   done       out  1      one-cycle pulse, result outputs updated this cycle
//   diff       out  WIDTH  a - b mod 2^WIDTH
//   borrow_out out  1      unsigned a < b
//   overflow   out  1      signed overflow of the subtraction
// -----------------------------------------------------------------------------

// Combinational 1-bit full adder used as the serial arithmetic cell.
module serial_subtractor_fa (
  input  logic x_i,
  input  logic y_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i ^ c_i;
  assign c_o = (x_i & y_i) | (x_i & c_i) | (y_i & c_i);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  // One extra counter bit so the count can reach WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q,   state_d;
  logic [WIDTH-1:0] sa_q,      sa_d;
  logic [WIDTH-1:0] sb_q,      sb_d;
  logic [WIDTH-1:0] part_q,    part_d;
  logic             carry_q,   carry_d;
  logic             cin_msb_q, cin_msb_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic [WIDTH-1:0] diff_q,    diff_d;
  logic             borrow_q,  borrow_d;
  logic             ovf_q,     ovf_d;

  // Arithmetic cell: current LSBs of both operand registers plus the carry.
  logic fa_sum;
  logic fa_cout;

  serial_subtractor_fa u_fa (
    .x_i (sa_q[0]),
    .y_i (sb_q[0]),
    .c_i (carry_q),
    .s_o (fa_sum),
    .c_o (fa_cout)
  );

  // Right-shifted copies of the operand and partial-result registers.
  // The new sum bit enters at the MSB so after WIDTH shifts the first
  // computed bit has reached bit 0.
  logic [WIDTH-1:0] sa_shift;
  logic [WIDTH-1:0] sb_shift;
  logic [WIDTH-1:0] part_shift;

  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign sa_shift[gi]   = sa_q[gi+1];
      assign sb_shift[gi]   = sb_q[gi+1];
      assign part_shift[gi] = part_q[gi+1];
    end
  endgenerate

  assign sa_shift[WIDTH-1]   = 1'b0;
  assign sb_shift[WIDTH-1]   = 1'b0;
  assign part_shift[WIDTH-1] = fa_sum;

  // Next-state and datapath logic.
  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    part_d    = part_q;
    carry_d   = carry_q;
    cin_msb_d = cin_msb_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    diff_d    = diff_q;
    borrow_d  = borrow_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction as a + ~b with the +1 supplied as the initial carry.
          sa_d      = a;
          sb_d      = ~b;
          part_d    = '0;
          carry_d   = 1'b1;
          cin_msb_d = 1'b0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        sa_d    = sa_shift;
        sb_d    = sb_shift;
        part_d  = part_shift;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q is the carry into the MSB during the final bit; keep it
          // for the signed overflow test.
          cin_msb_d = carry_q;
          state_d   = DONE;
        end
      end

      DONE: begin
        diff_d   = part_q;
        borrow_d = ~carry_q;
        ovf_d    = cin_msb_q ^ carry_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers. Reset takes priority over everything, including start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sa_q      <= '0;
      sb_q      <= '0;
      part_q    <= '0;
      carry_q   <= 1'b0;
      cin_msb_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      diff_q    <= '0;
      borrow_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      part_q    <= part_d;
      carry_q   <= carry_d;
      cin_msb_q <= cin_msb_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      diff_q    <= diff_d;
      borrow_q  <= borrow_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Scoreboard bench for serial_subtractor (WIDTH=8). Expected results are
// computed from the operands when an operation is issued, queued, and popped
// when the DUT pulses done. Each scenario task does its own checks.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;
  logic       overflow;

  typedef struct packed {
    logic [7:0] d;
    logic       br;
    logic       ov;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mdl_diff;
  int         n_cmp  = 0;
  int         n_fail = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Independent reference: plain subtraction and the textbook signed rule.
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    exp_t r;
    r.d  = x - y;
    r.br = (x < y);
    r.ov = (x[7] != y[7]) && (r.d[7] != x[7]);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
    tick; tick;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (diff !== 8'd0) begin n_fail++; $display("FAIL reset_diff: got %0h expected 0", diff); end
    n_cmp++; if (borrow_out !== 1'b0) begin n_fail++; $display("FAIL reset_borrow: got %b expected 0", borrow_out); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    rst = 1'b0;
    mdl_diff = 8'd0;
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
    $display("reset: busy=%b done=%b diff=%0h", busy, done, diff);
  endtask

  // Issue one operation and follow it to completion, checking latency,
  // busy duration, result stability and the scored result.
  task automatic run_op(input logic [7:0] ai, input logic [7:0] bi, input string tag);
    exp_t e;
    exp_t got;
    int   lat;
    int   busy_cnt;
    bit   seen;
    a = ai; b = bi; start = 1'b1;
    exp_q.push_back(model(ai, bi));
    tick;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    lat = 0; busy_cnt = 0; seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = c - 1;
      end else begin
        if (busy === 1'b1) busy_cnt++;
        n_cmp++;
        if (diff !== mdl_diff) begin
          n_fail++;
          $display("FAIL %s_hold: got %0h expected %0h at cycle %0d", tag, diff, mdl_diff, c);
        end
        tick;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: got no done expected done within 20 cycles", tag);
      void'(exp_q.pop_front());
    end else begin
      n_cmp++; if (lat != 9) begin n_fail++; $display("FAIL %s_latency: got %0d expected 9", tag, lat); end
      n_cmp++; if (busy_cnt != 9) begin n_fail++; $display("FAIL %s_busy_len: got %0d expected 9", tag, busy_cnt); end
      e = exp_q.pop_front();
      got.d = diff; got.br = borrow_out; got.ov = overflow;
      n_cmp++; if (diff !== e.d) begin n_fail++; $display("FAIL %s_diff: got %0h expected %0h", tag, diff, e.d); end
      n_cmp++; if (borrow_out !== e.br) begin n_fail++; $display("FAIL %s_borrow: got %b expected %b", tag, borrow_out, e.br); end
      n_cmp++; if (overflow !== e.ov) begin n_fail++; $display("FAIL %s_ovf: got %b expected %b", tag, overflow, e.ov); end
      mdl_diff = e.d;
      $display("op %s: a=%0h b=%0h diff=%0h borrow=%b ovf=%b latency=%0d", tag, ai, bi, got.d, got.br, got.ov, lat);
      tick;
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s_pulse: got %b expected 0", tag, done); end
      n_cmp++; if (diff !== e.d) begin n_fail++; $display("FAIL %s_after: got %0h expected %0h", tag, diff, e.d); end
    end
  endtask

  task automatic test_basic;
    run_op(8'd100, 8'd37, "sub_100_37");
    run_op(8'd5,   8'd10, "sub_5_10");
    run_op(8'd0,   8'd0,  "sub_0_0");
    run_op(8'h80,  8'h01, "sub_80_01");
    run_op(8'h7F,  8'hFF, "sub_7f_ff");
  endtask

  task automatic test_reset_abort;
    int ndone;
    a = 8'd50; b = 8'd7; start = 1'b1;
    tick;                      // accepted; now in cycle 1 of the operation
    start = 1'b0;
    tick; tick; tick;          // cycle 4
    rst = 1'b1;
    tick;
    rst = 1'b0;
    mdl_diff = 8'd0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_cmp++; if (diff !== 8'd0) begin n_fail++; $display("FAIL abort_diff: got %0h expected 0", diff); end
    n_cmp++; if (borrow_out !== 1'b0) begin n_fail++; $display("FAIL abort_borrow: got %b expected 0", borrow_out); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL abort_ovf: got %b expected 0", overflow); end
    // Reset must beat a simultaneous start.
    rst = 1'b1; start = 1'b1;
    tick;
    rst = 1'b0; start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_vs_start: got busy=%b expected 0", busy); end
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (done === 1'b1) ndone++;
      tick;
    end
    n_cmp++; if (ndone != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", ndone); end
    $display("abort: busy=%b diff=%0h dones=%0d", busy, diff, ndone);
    run_op(8'd9, 8'd4, "after_abort");
  endtask

  task automatic test_ignored_start;
    exp_t e;
    int   ndone;
    a = 8'd20; b = 8'd3; start = 1'b1;
    exp_q.push_back(model(8'd20, 8'd3));
    tick;                      // accepted; now in cycle 1
    start = 1'b0;
    a = 8'd1; b = 8'd1;
    ndone = 0;
    for (int c = 1; c <= 25; c++) begin
      start = (c == 3 || c == 9);
      tick;
      if (done === 1'b1) begin
        ndone++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL ignored_extra_done: got done at cycle %0d expected none", c + 1);
        end else begin
          e = exp_q.pop_front();
          if (diff !== e.d) begin n_fail++; $display("FAIL ignored_diff: got %0h expected %0h", diff, e.d); end
          mdl_diff = e.d;
          $display("op ignored_start: a=14 b=3 diff=%0h at cycle %0d", diff, c + 1);
        end
      end
    end
    start = 1'b0;
    n_cmp++; if (ndone != 1) begin n_fail++; $display("FAIL ignored_done_count: got %0d expected 1", ndone); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ignored_queue: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   ndone;
    int   last_t;
    a = 8'd200; b = 8'd100; start = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back(model(8'd200, 8'd100));
    ndone = 0; last_t = 0;
    for (int t = 1; t <= 30; t++) begin
      tick;
      if (done === 1'b1) begin
        ndone++;
        n_cmp++; if (t != last_t + 10) begin n_fail++; $display("FAIL b2b_period: got done at %0d expected %0d", t, last_t + 10); end
        last_t = t;
        e = exp_q.pop_front();
        n_cmp++; if (diff !== e.d) begin n_fail++; $display("FAIL b2b_diff: got %0h expected %0h", diff, e.d); end
        mdl_diff = e.d;
        $display("op back_to_back: a=c8 b=64 diff=%0h at t=%0d", diff, t);
      end else begin
        n_cmp++;
        if (diff !== mdl_diff) begin n_fail++; $display("FAIL b2b_hold: got %0h expected %0h at t=%0d", diff, mdl_diff, t); end
      end
    end
    start = 1'b0;
    n_cmp++; if (ndone != 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", ndone); end
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy=%b expected 0", busy); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
    mdl_diff = 8'd0;
    test_reset;
    test_basic;
    test_reset_abort;
    test_ignored_start;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
